sub_mag_serial: RTL and testbench



---
 rtl/sub_serial_pkg.sv | 18 +
 rtl/digit_addsub.sv | 19 +
 rtl/sub_mag_serial.sv | 128 ++++++++++++
 tb/tb_sub_mag_serial.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_serial_pkg.sv
// Shared types and helpers for the digit-serial subtract / magnitude unit.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    NEG  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Digit counter width; a single-digit pass still needs a 1-bit counter.
  function automatic int cnt_width(input int w, input int d);
    int n;
    n = w / d;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_addsub.sv
// D-bit ripple adder with optional inversion of y; shared by the subtract
// and negate passes.
module digit_addsub #(
  parameter int D = 4
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         inv_y,
  input  logic         cin,
  output logic [D-1:0] s,
  output logic         cout
);

  logic [D-1:0] y_eff;

  assign y_eff     = inv_y ? ~y : y;
  assign {cout, s} = {1'b0, x} + {1'b0, y_eff} + {{D{1'b0}}, cin};

endmodule

// File: rtl/sub_mag_serial.sv
// Digit-serial A - B: returns |A - B| with a sign flag, or the raw
// two's-complement difference, D bits per cycle with valid/ready handshakes.
module sub_mag_serial
  import sub_serial_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         neg,
  output logic         busy
);

  localparam int N  = W / D;
  localparam int CW = cnt_width(W, D);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if ((W % D) != 0 || D > W) begin : g_bad_params
    $error("sub_mag_serial: W must be a multiple of D and D <= W");
  end

  state_t        state_reg, state_next;
  logic [W-1:0]  a_sh_reg, b_sh_reg, r_reg;
  logic          carry_reg, mode_reg, neg_reg;
  logic [CW-1:0] cnt_reg;

  logic [D-1:0]  x_dig, y_dig, s_dig;
  logic          inv_y, cout, last;

  assign last = (cnt_reg == LAST);

  // SUB feeds a + ~b + carry; NEG recirculates ~r + carry to negate the result.
  always_comb begin
    x_dig = a_sh_reg[D-1:0];
    y_dig = b_sh_reg[D-1:0];
    inv_y = 1'b1;
    if (state_reg == NEG) begin
      x_dig = ~r_reg[D-1:0];
      y_dig = '0;
      inv_y = 1'b0;
    end
  end

  digit_addsub #(.D(D)) u_digit (
    .x    (x_dig),
    .y    (y_dig),
    .inv_y(inv_y),
    .cin  (carry_reg),
    .s    (s_dig),
    .cout (cout)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = SUB;
      SUB:  if (last) state_next = (!cout && !mode_reg) ? NEG : DONE;
      NEG:  if (last) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      r_reg     <= '0;
      carry_reg <= 1'b0;
      mode_reg  <= 1'b0;
      neg_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            mode_reg  <= mode;
            neg_reg   <= 1'b0;
            carry_reg <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        SUB: begin
          a_sh_reg  <= a_sh_reg >> D;
          b_sh_reg  <= b_sh_reg >> D;
          r_reg     <= (r_reg >> D) | (W'(s_dig) << (W - D));
          carry_reg <= cout;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last) begin
            // No carry out of a + ~b + 1 means a borrow, i.e. a < b.
            neg_reg   <= ~cout;
            carry_reg <= 1'b1;
            cnt_reg   <= '0;
          end
        end
        NEG: begin
          r_reg     <= (r_reg >> D) | (W'(s_dig) << (W - D));
          carry_reg <= cout;
          cnt_reg   <= last ? '0 : cnt_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign diff      = r_reg;
  assign neg       = neg_reg;

endmodule

// File: tb/tb_sub_mag_serial.sv
// Scoreboard bench: directed W=8/D=4 cases plus a random W=16/D=4 run,
// each result checked against an arithmetic reference model.
module tb_sub_mag_serial;

  typedef struct {
    int unsigned diff;
    bit          neg;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid8 = 0, in_ready8, mode8 = 0, out_valid8, out_ready8 = 1, neg8, busy8;
  logic [7:0]  a8 = 0, b8 = 0, diff8;
  logic        in_valid16 = 0, in_ready16, mode16 = 0, out_valid16, out_ready16 = 1, neg16, busy16;
  logic [15:0] a16 = 0, b16 = 0, diff16;

  sub_mag_serial #(.W(8), .D(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .neg(neg8), .busy(busy8)
  );

  sub_mag_serial #(.W(16), .D(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16), .out_ready(out_ready16),
    .diff(diff16), .neg(neg16), .busy(busy16)
  );

  int   vectors = 0;
  int   errs = 0;
  int   cyc = 0;
  exp_t sbq8[$];
  exp_t sbq16[$];
  bit   rand_phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int unsigned act, input int unsigned expv);
    vectors++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: magnitude/sign from plain unsigned arithmetic, latency from pass count.
  function automatic exp_t model(input int unsigned av, input int unsigned bv, input bit m, input int w);
    exp_t        e;
    int          n;
    int unsigned mask;
    n     = w / 4;
    mask  = (32'd1 << w) - 1;
    e.neg = (av < bv);
    e.diff = (e.neg && !m) ? (bv - av) : ((av - bv) & mask);
    e.lat  = (e.neg && !m) ? 2 * n + 1 : n + 1;
    return e;
  endfunction

  // Monitors: latency on out_valid rise, value compare on each output handshake.
  int acc8 = 0, acc16 = 0;
  bit ov8_prev = 0, ov16_prev = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ov8_prev <= 0;
    end else begin
      if (in_valid8 && in_ready8) acc8 <= cyc + 1;
      if (out_valid8 && !ov8_prev && sbq8.size() > 0) check("lat8", cyc + 1 - acc8, sbq8[0].lat);
      if (out_valid8 && out_ready8) begin
        if (sbq8.size() == 0) check("spurious8", 1, 0);
        else begin
          e = sbq8.pop_front();
          check("diff8", diff8, e.diff);
          check("neg8", neg8, e.neg);
          $display("w8  diff=%02h neg=%0d", diff8, neg8);
        end
      end
      ov8_prev <= out_valid8;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      ov16_prev <= 0;
    end else begin
      if (in_valid16 && in_ready16) acc16 <= cyc + 1;
      if (out_valid16 && !ov16_prev && sbq16.size() > 0) check("lat16", cyc + 1 - acc16, sbq16[0].lat);
      if (out_valid16 && out_ready16) begin
        if (sbq16.size() == 0) check("spurious16", 1, 0);
        else begin
          e = sbq16.pop_front();
          check("diff16", diff16, e.diff);
          check("neg16", neg16, e.neg);
          $display("w16 diff=%04h neg=%0d", diff16, neg16);
        end
      end
      ov16_prev <= out_valid16;
    end
  end

  // Random backpressure for the wide unit during the random run.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready16 = rand_phase ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic m);
    bit done = 0;
    @(posedge clk); #1;
    a8 = av; b8 = bv; mode8 = m; in_valid8 = 1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready8) begin
        sbq8.push_back(model(av, bv, m, 8));
        @(posedge clk); #1;
        in_valid8 = 0;
        done = 1;
      end
    end
    if (!done) begin check("accept8_timeout", 0, 1); in_valid8 = 0; end
  endtask

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic m);
    bit done = 0;
    @(posedge clk); #1;
    a16 = av; b16 = bv; mode16 = m; in_valid16 = 1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (in_ready16) begin
        sbq16.push_back(model(av, bv, m, 16));
        @(posedge clk); #1;
        in_valid16 = 0;
        done = 1;
      end
    end
    if (!done) begin check("accept16_timeout", 0, 1); in_valid16 = 0; end
  endtask

  task automatic drain8();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sbq8.size() == 0 && in_ready8) done = 1;
    end
    if (!done) check("drain8_timeout", 0, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    logic [15:0] ra, rb;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid8, 0);
    check("rst_in_ready", in_ready8, 1);
    check("rst_busy", busy8, 0);
    check("rst_diff", diff8, 0);
    check("rst_neg", neg8, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Magnitude, negate pass, raw mode, boundaries
    send8(8'h5A, 8'h21, 0); drain8();
    send8(8'h21, 8'h5A, 0); drain8();
    send8(8'h21, 8'h5A, 1); drain8();
    send8(8'hFF, 8'hFF, 0); drain8();
    send8(8'h00, 8'h80, 0); drain8();
    send8(8'h00, 8'h01, 0); drain8();
    send8(8'h80, 8'h00, 1); drain8();
    send8(8'h00, 8'hFF, 1); drain8();

    // Hold in DONE while in_valid pulses
    out_ready8 = 0;
    send8(8'h5A, 8'h21, 0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid8) got = 1;
    end
    check("hold_reach_done", got, 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid8 = i[0]; a8 = 8'h01; b8 = 8'hF0; mode8 = 1;
      @(negedge clk);
      check("hold_diff", diff8, 8'h39);
      check("hold_neg", neg8, 0);
      check("hold_in_ready", in_ready8, 0);
      check("hold_out_valid", out_valid8, 1);
    end
    @(posedge clk); #1;
    in_valid8 = 0; out_ready8 = 1;
    @(posedge clk); #1;
    out_ready8 = 0;
    @(negedge clk);
    check("release_in_ready", in_ready8, 1);
    check("release_no_latch", busy8, 0);
    check("release_queue_empty", sbq8.size(), 0);
    out_ready8 = 1;

    // Reset during the negate pass
    send8(8'h21, 8'h5A, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", busy8, 1);
    check("pre_rst_out_valid", out_valid8, 0);
    rst_n = 0;
    #1;
    check("mid_rst_out_valid", out_valid8, 0);
    check("mid_rst_in_ready", in_ready8, 1);
    check("mid_rst_diff", diff8, 0);
    check("mid_rst_neg", neg8, 0);
    sbq8.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1;
    send8(8'h5A, 8'h21, 0); drain8();

    // Random run on the wide unit with output stalls
    rand_phase = 1;
    for (int t = 0; t < 1000; t++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = ra;
        1: begin ra = 16'h0000; rb = 16'h8000; end
        2: begin ra = 16'h0000; rb = 16'hFFFF; end
        default: ;
      endcase
      send16(ra, rb, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    got = 0;
    for (int i = 0; i < 500 && !got; i++) begin
      @(negedge clk);
      if (sbq16.size() == 0 && in_ready16) got = 1;
    end
    check("drain16", got, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
